mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Moore FSM controller for the multicycle MIPS datapath; sits directly upstream of the 32-bit ALU.
//  Decodes opcode/funct from the instruction register and sequences the datapath enables.
//  Drives the ALU's 4-bit op select; consumes the ALU zero flag to resolve beq.
//  Supports R-type (add/sub/and/or/xor/nor/slt), lw, sw, beq, addi, j.
// PARAMETERS
//  (none) -- all encodings are fixed constants in the shared package
// PORTS
//  clk         in   1  single clock, rising edge
//  reset       in   1  synchronous, active-high
//  opcode      in   6  instr[31:26] from instruction register
//  funct       in   6  instr[5:0] from instruction register
//  alu_zero    in   1  1 when ALU result == 0 (this block's required polarity)
//  pc_en       out  1  PC load = pc_write | (branch & alu_zero)
//  iord        out  1  0: mem addr = PC, 1: mem addr = ALUOut
//  mem_write   out  1  data memory write strobe
//  ir_write    out  1  instruction register load
//  reg_dst     out  1  0: rt, 1: rd as write register
//  mem_to_reg  out  1  0: ALUOut, 1: memory data to register file
//  reg_write   out  1  register file write strobe
//  alu_src_a   out  1  0: PC, 1: reg A
//  alu_src_b   out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  alu_op      out  4  ADD 0000, SUB 0010, AND 0100, OR 0101, XOR 0110, NOR 0111, SLT 1010
//  pc_src      out  2  00 ALU result, 01 ALUOut, 10 jump target
//  state_dbg   out  4  current state encoding (debug only)
// BEHAVIOUR
//  - 4-bit state reg; outputs are pure decode of state (Moore), except pc_en uses alu_zero.
//  - Reset: reset=1 at rising edge -> state=FETCH(0). While reset=1, pc_en, mem_write,
//    ir_write, reg_write are forced 0 regardless of state; other outputs = FETCH decode.
//    Reset mid-instruction aborts it; no partial write occurs after the reset edge.
//  - Unlisted outputs in a state are 0 (alu_op=ADD, alu_src_b=00).
//  - States / outputs / next state:
//    FETCH(0)   iord=0 src_a=0 src_b=01 ADD pc_src=00 ir_write=1 pc_write=1 -> DECODE
//    DECODE(1)  src_a=0 src_b=11 ADD (branch target into ALUOut);
//               lw|sw->MEMADR, R->EXEC, beq->BRANCH, addi->ADDIEX, j->JUMP, other->FETCH
//    MEMADR(2)  src_a=1 src_b=10 ADD; lw->MEMRD, sw->MEMWR
//    MEMRD(3)   iord=1 -> MEMWB
//    MEMWB(4)   reg_dst=0 mem_to_reg=1 reg_write=1 -> FETCH
//    MEMWR(5)   iord=1 mem_write=1 -> FETCH
//    EXEC(6)    src_a=1 src_b=00 alu_op=funct map -> ALUWB
//    ALUWB(7)   reg_dst=1 mem_to_reg=0 reg_write=1 (0 if funct unsupported) -> FETCH
//    BRANCH(8)  src_a=1 src_b=00 SUB pc_src=01 branch=1 -> FETCH
//    ADDIEX(9)  src_a=1 src_b=10 ADD -> ADDIWB
//    ADDIWB(10) reg_dst=0 mem_to_reg=0 reg_write=1 -> FETCH
//    JUMP(11)   pc_src=10 pc_write=1 -> FETCH
//    12..15     illegal: all strobes 0, -> FETCH next cycle
//  - funct map: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR,
//    101010 SLT; any other funct -> alu_op=ADD with write suppressed in ALUWB.
//  - Cycles per instr (FETCH..last, inclusive): lw 5, sw 4, R 4, addi 4, beq 3, j 3.
//  - opcode/funct sampled only in DECODE/MEMADR/EXEC/ALUWB; IR stable after FETCH.
// STRUCTURE
//  - Package mips_pkg: state enum, opcode consts (R 000000, lw 100011, sw 101011,
//    beq 000100, addi 001000, j 000010), funct consts, ALU op consts (shared with ALU).
//  - Sub-module alu_decoder: combinational funct + state-class -> alu_op, funct_valid.
//  - Top: state register, next-state logic, output decode, pc_en gate.
// TESTING
//  - Reset held 3 cycles mid-MEMWR -> state_dbg=0, mem_write=0 during reset and after.
//  - opcode=100011 -> states 0,1,2,3,4; reg_write=1 & mem_to_reg=1 only in cycle 5.
//  - opcode=0, funct=101010 -> EXEC alu_op=1010; ALUWB reg_dst=1 reg_write=1.
//  - opcode=000100, alu_zero=1 -> pc_en=1 in BRANCH with alu_op=0010; alu_zero=0 -> pc_en=0.
//  - opcode=000010 -> 3 cycles, pc_src=10 pc_en=1 in JUMP; opcode=111111 -> DECODE->FETCH, no strobes.
//  - opcode=0, funct=000000 -> reg_write stays 0 in ALUWB; next FETCH proceeds normally.

Source files
------------

// File: rtl/mips_multicycle_ctrl_pkg.sv
// rtl/mips_multicycle_ctrl_pkg.sv - shared encodings for the multicycle MIPS controller and ALU
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  // What the current state wants from the ALU: a fixed add/sub or the funct-selected op
  typedef enum logic [1:0] {
    ALU_CLASS_ADD   = 2'd0,
    ALU_CLASS_SUB   = 2'd1,
    ALU_CLASS_FUNCT = 2'd2
  } alu_class_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1010;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - controller <-> datapath signal bundle
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_zero;
  logic       pc_en;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_op;
  logic [1:0] pc_src;
  logic [3:0] state_dbg;

  // Controller side: consumes instruction fields and zero flag, drives datapath controls
  modport master (
    input  opcode, funct, alu_zero,
    output pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, state_dbg
  );

  // Datapath side
  modport slave (
    output opcode, funct, alu_zero,
    input  pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, state_dbg
  );
endinterface

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// rtl/mips_multicycle_ctrl_alu_decoder.sv - funct and state class to ALU op select
module alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0]  funct,
  input  alu_class_t  alu_class,
  output logic [3:0]  alu_op,
  output logic        funct_valid
);

  logic [3:0] funct_op;

  // Map R-type funct to an ALU op; unsupported codes fall back to ADD and are flagged
  always_comb begin
    funct_op    = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      FN_ADD:  funct_op = ALU_ADD;
      FN_SUB:  funct_op = ALU_SUB;
      FN_AND:  funct_op = ALU_AND;
      FN_OR:   funct_op = ALU_OR;
      FN_XOR:  funct_op = ALU_XOR;
      FN_NOR:  funct_op = ALU_NOR;
      FN_SLT:  funct_op = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
  end

  // Choose between the fixed ops used for address/branch math and the funct op
  always_comb begin
    alu_op = ALU_ADD;
    case (alu_class)
      ALU_CLASS_SUB:   alu_op = ALU_SUB;
      ALU_CLASS_FUNCT: alu_op = funct_op;
      default:         alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - Moore FSM sequencing the multicycle MIPS datapath
module mips_multicycle_ctrl
  import mips_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  mips_multicycle_ctrl_if.master  bus
);

  state_t     state;
  state_t     next_state;
  state_t     dec_state;
  alu_class_t alu_class;
  logic [3:0] alu_op;
  logic       funct_valid;

  logic pc_write;
  logic branch;
  logic iord;
  logic mem_write;
  logic ir_write;
  logic reg_dst;
  logic mem_to_reg;
  logic reg_write;
  logic alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;

  // State register; reset returns to FETCH, aborting any instruction in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; opcode is only looked at in DECODE and MEMADR
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JUMP;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (bus.opcode == OP_LW) begin
          next_state = S_MEMRD;
        end else if (bus.opcode == OP_SW) begin
          next_state = S_MEMWR;
        end else begin
          next_state = S_FETCH;
        end
      end
      S_MEMRD:  next_state = S_MEMWB;
      S_EXEC:   next_state = S_ALUWB;
      S_ADDIEX: next_state = S_ADDIWB;
      default:  next_state = S_FETCH;
    endcase
  end

  // While reset is held the non-strobe outputs show the FETCH decode
  assign dec_state = reset ? S_FETCH : state;

  // Output decode of the (reset-adjusted) state; unused states leave everything at 0
  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_class  = ALU_CLASS_ADD;
    pc_src     = PCSRC_ALU;
    case (dec_state)
      S_FETCH: begin
        alu_src_b = SRCB_FOUR;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM2;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        iord = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_class = ALU_CLASS_FUNCT;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = funct_valid;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_class = ALU_CLASS_SUB;
        pc_src    = PCSRC_ALUOUT;
        branch    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
      end
      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      default: begin
        pc_write = 1'b0;
      end
    endcase
  end

  alu_decoder u_alu_decoder (
    .funct       (bus.funct),
    .alu_class   (alu_class),
    .alu_op      (alu_op),
    .funct_valid (funct_valid)
  );

  // Write strobes are killed combinationally during reset so nothing commits mid-abort
  assign bus.pc_en      = (pc_write | (branch & bus.alu_zero)) & ~reset;
  assign bus.mem_write  = mem_write & ~reset;
  assign bus.ir_write   = ir_write & ~reset;
  assign bus.reg_write  = reg_write & ~reset;
  assign bus.iord       = iord;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_op;
  assign bus.pc_src     = pc_src;
  assign bus.state_dbg  = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - directed scoreboard bench for the multicycle controller
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_en;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] pc_src;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t  exp_q[$];
  string tag_q[$];

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input logic [3:0] s, input logic pe, input logic io,
                              input logic mw, input logic iw, input logic rd,
                              input logic mr, input logic rw, input logic sa,
                              input logic [1:0] sb, input logic [3:0] op,
                              input logic [1:0] ps);
    vec_t v;
    v = '{s, pe, io, mw, iw, rd, mr, rw, sa, sb, op, ps};
    return v;
  endfunction

  function automatic vec_t observe();
    vec_t v;
    v = '{bus.state_dbg, bus.pc_en, bus.iord, bus.mem_write, bus.ir_write, bus.reg_dst,
          bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_src};
    return v;
  endfunction

  // Expected per-state vectors taken directly from the state/output table
  function automatic vec_t v_fetch();  return mk(4'd0, 1,0,0,1,0,0,0,0, 2'b01, 4'b0000, 2'b00); endfunction
  function automatic vec_t v_rst(input logic [3:0] s); return mk(s, 0,0,0,0,0,0,0,0, 2'b01, 4'b0000, 2'b00); endfunction
  function automatic vec_t v_decode(); return mk(4'd1, 0,0,0,0,0,0,0,0, 2'b11, 4'b0000, 2'b00); endfunction
  function automatic vec_t v_memadr(); return mk(4'd2, 0,0,0,0,0,0,0,1, 2'b10, 4'b0000, 2'b00); endfunction
  function automatic vec_t v_memrd();  return mk(4'd3, 0,1,0,0,0,0,0,0, 2'b00, 4'b0000, 2'b00); endfunction
  function automatic vec_t v_memwb();  return mk(4'd4, 0,0,0,0,0,1,1,0, 2'b00, 4'b0000, 2'b00); endfunction
  function automatic vec_t v_memwr();  return mk(4'd5, 0,1,1,0,0,0,0,0, 2'b00, 4'b0000, 2'b00); endfunction
  function automatic vec_t v_exec(input logic [3:0] op); return mk(4'd6, 0,0,0,0,0,0,0,1, 2'b00, op, 2'b00); endfunction
  function automatic vec_t v_aluwb(input logic rw); return mk(4'd7, 0,0,0,0,1,0,rw,0, 2'b00, 4'b0000, 2'b00); endfunction
  function automatic vec_t v_branch(input logic z); return mk(4'd8, z,0,0,0,0,0,0,1, 2'b00, 4'b0010, 2'b01); endfunction
  function automatic vec_t v_addiex(); return mk(4'd9, 0,0,0,0,0,0,0,1, 2'b10, 4'b0000, 2'b00); endfunction
  function automatic vec_t v_addiwb(); return mk(4'd10, 0,0,0,0,0,0,1,0, 2'b00, 4'b0000, 2'b00); endfunction
  function automatic vec_t v_jump();   return mk(4'd11, 1,0,0,0,0,0,0,0, 2'b00, 4'b0000, 2'b10); endfunction

  task automatic push(input string tag, input vec_t v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check_one();
    vec_t  e;
    vec_t  o;
    string t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_underflow: observed empty queue, required an entry");
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o = observe();
      assert (o === e) else begin
        errors++;
        $error("FAIL %s: observed %h required %h", t, o, e);
      end
    end
  endtask

  // Checks n consecutive states starting with the one currently held, without advancing past the last
  task automatic run_partial(input int n);
    #1;
    check_one();
    for (int i = 1; i < n; i++) begin
      @(posedge clk);
      #1;
      check_one();
    end
  endtask

  // Checks a whole instruction and steps into the following FETCH
  task automatic run_cycles(input int n);
    run_partial(n);
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    bus.opcode   = op;
    bus.funct    = fn;
    bus.alu_zero = z;
  endtask

  initial begin
    logic [5:0] fns [7];
    logic [3:0] ops [7];
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010};
    ops = '{4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1010};
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    set_instr(6'b100011, 6'b000000, 1'b0);

    // Reset state, held for two edges
    @(posedge clk);
    #1;
    push("reset_0", v_rst(4'd0));
    check_one();
    @(posedge clk);
    #1;
    push("reset_1", v_rst(4'd0));
    check_one();
    reset = 1'b0;

    // lw: five states, register write only in the last
    set_instr(6'b100011, 6'b000000, 1'b0);
    push("lw_fetch", v_fetch());
    push("lw_decode", v_decode());
    push("lw_memadr", v_memadr());
    push("lw_memrd", v_memrd());
    push("lw_memwb", v_memwb());
    run_cycles(5);

    // sw aborted by a three-cycle reset in MEMWR
    set_instr(6'b101011, 6'b000000, 1'b0);
    push("sw_fetch", v_fetch());
    push("sw_decode", v_decode());
    push("sw_memadr", v_memadr());
    push("sw_memwr", v_memwr());
    run_partial(4);
    reset = 1'b1;
    push("sw_reset_pre_edge", v_rst(4'd5));
    #1;
    check_one();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      push("sw_reset_held", v_rst(4'd0));
      check_one();
    end
    reset = 1'b0;

    // Complete sw after the abort
    push("sw2_fetch", v_fetch());
    push("sw2_decode", v_decode());
    push("sw2_memadr", v_memadr());
    push("sw2_memwr", v_memwr());
    run_cycles(4);

    // Every supported R-type funct
    for (int k = 0; k < 7; k++) begin
      set_instr(6'b000000, fns[k], 1'b0);
      push("r_fetch", v_fetch());
      push("r_decode", v_decode());
      push($sformatf("r_exec_%b", fns[k]), v_exec(ops[k]));
      push("r_aluwb", v_aluwb(1'b1));
      run_cycles(4);
    end

    // beq taken and not taken
    set_instr(6'b000100, 6'b000000, 1'b1);
    push("beq_t_fetch", v_fetch());
    push("beq_t_decode", v_decode());
    push("beq_t_branch", v_branch(1'b1));
    run_cycles(3);
    set_instr(6'b000100, 6'b000000, 1'b0);
    push("beq_nt_fetch", v_fetch());
    push("beq_nt_decode", v_decode());
    push("beq_nt_branch", v_branch(1'b0));
    run_cycles(3);

    // j
    set_instr(6'b000010, 6'b000000, 1'b0);
    push("j_fetch", v_fetch());
    push("j_decode", v_decode());
    push("j_jump", v_jump());
    run_cycles(3);

    // Unknown opcode returns straight to FETCH
    set_instr(6'b111111, 6'b101010, 1'b1);
    push("ill_fetch", v_fetch());
    push("ill_decode", v_decode());
    run_cycles(2);

    // Unsupported funct: ALU op falls back to ADD and no register write
    set_instr(6'b000000, 6'b000000, 1'b0);
    push("rbad_fetch", v_fetch());
    push("rbad_decode", v_decode());
    push("rbad_exec", v_exec(4'b0000));
    push("rbad_aluwb", v_aluwb(1'b0));
    run_cycles(4);

    // addi proceeds normally afterwards
    set_instr(6'b001000, 6'b000000, 1'b0);
    push("addi_fetch", v_fetch());
    push("addi_decode", v_decode());
    push("addi_ex", v_addiex());
    push("addi_wb", v_addiwb());
    run_cycles(4);

    // Back in FETCH after the last instruction
    push("final_fetch", v_fetch());
    run_partial(1);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
